// File: rtl/sram_fifo_pkg.sv
// Shared types and helpers for the SRAM-backed FIFO controller.
// Grant encoding, skid depth and the non-power-of-two pointer wrap.
package sram_fifo_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    localparam int SKID_DEPTH = 2;
    localparam int PTR_W      = 16;

    // Wraps at depth-1 by compare so depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p,
        input int unsigned      depth
    );
        ptr_inc = (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Producer/consumer valid-ready handshake bundle for sram_fifo_ctrl.
// slave = FIFO side, master = producer/consumer side.
interface sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 9
) ();

    logic                  i_wrValid;
    logic                  o_wrReady;
    logic [DATA_WIDTH-1:0] i_wrData;
    logic                  o_rdValid;
    logic                  i_rdReady;
    logic [DATA_WIDTH-1:0] o_rdData;

    modport slave (
        input  i_wrValid, i_wrData, i_rdReady,
        output o_wrReady, o_rdValid, o_rdData
    );

    modport master (
        output i_wrValid, i_wrData, i_rdReady,
        input  o_wrReady, o_rdValid, o_rdData
    );

endinterface

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer that absorbs the RAM's one-cycle read latency.
// Entry e0 is always the head; fill and pop may coincide.
module fifo_out_skid
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] e0;
    logic [DATA_WIDTH-1:0] e1;
    logic                  take;

    assign take  = pop && (count != 2'd0);
    assign valid = (count != 2'd0);
    assign head  = e0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else begin
            unique case ({fill, take})
                2'b10: begin
                    if (count == 2'(SKID_DEPTH - 1))
                        e1 <= data;
                    else
                        e0 <= data;
                    count <= count + 1'b1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 1'b1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= data;
                    end else begin
                        e0 <= e1;
                        e1 <= data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller owning one single-port-per-edge block RAM plus output skid.
// Optional FIFO_ALMOST_EN adds registered o_almostFull / o_almostEmpty.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 9,
    parameter int DEPTH        = 512,
    parameter int ALMOST_FULL  = DEPTH - 4,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    sram_fifo_ctrl_if.slave       bus,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
`ifdef FIFO_ALMOST_EN
    output logic                  o_almostFull,
    output logic                  o_almostEmpty,
`endif
    output logic [ADDR_WIDTH-1:0] o_AddrWrite,
    output logic [ADDR_WIDTH-1:0] o_AddrRead,
    output logic                  o_write,
    output logic [DATA_WIDTH-1:0] o_Data,
    input  logic [DATA_WIDTH-1:0] i_Data
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         mem_count;
    logic                  inflight;
    logic                  starve;
    logic [1:0]            skid_count;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  rd_iss;
    logic                  wr_rdy;
    logic                  push;
    gnt_e                  gnt;

    assign o_full = (mem_count == CW'(DEPTH));

    // Reads only look at registered state so wrValid cannot loop into ready.
    assign rd_iss = (mem_count != '0)
                 && (({1'b0, skid_count} + {2'b00, inflight}) < 3'(SKID_DEPTH))
                 && !starve;

    assign wr_rdy = i_rst_n && !o_full && !rd_iss;
    assign push   = bus.i_wrValid && wr_rdy;

    always_comb begin
        gnt = GNT_NONE;
        unique case (1'b1)
            push:    gnt = GNT_WR;
            rd_iss:  gnt = GNT_RD;
            default: gnt = GNT_NONE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
            starve    <= 1'b0;
        end else begin
            inflight <= (gnt == GNT_RD);
            unique case (gnt)
                GNT_WR: begin
                    wr_ptr    <= ADDR_WIDTH'(ptr_inc(PTR_W'(wr_ptr), DEPTH));
                    mem_count <= mem_count + 1'b1;
                end
                GNT_RD: begin
                    rd_ptr    <= ADDR_WIDTH'(ptr_inc(PTR_W'(rd_ptr), DEPTH));
                    mem_count <= mem_count - 1'b1;
                end
                default: ;
            endcase
            // A blocked, non-full producer pre-empts the next read slot.
            if (push)
                starve <= 1'b0;
            else if (bus.i_wrValid && !o_full)
                starve <= 1'b1;
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .fill  (inflight),
        .data  (i_Data),
        .pop   (bus.i_rdReady),
        .valid (skid_valid),
        .head  (skid_data),
        .count (skid_count)
    );

    assign bus.o_wrReady = wr_rdy;
    assign bus.o_rdValid = skid_valid;
    assign bus.o_rdData  = skid_data;

    assign o_count     = mem_count + CW'(inflight) + CW'(skid_count);
    assign o_empty     = (o_count == '0);
    assign o_write     = (gnt == GNT_WR);
    assign o_AddrWrite = wr_ptr;
    assign o_AddrRead  = rd_ptr;
    assign o_Data      = bus.i_wrData;

`ifdef FIFO_ALMOST_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_almostFull  <= 1'b0;
            o_almostEmpty <= 1'b1;
        end else begin
            o_almostFull  <= (o_count >= CW'(ALMOST_FULL));
            o_almostEmpty <= (o_count <= CW'(ALMOST_EMPTY));
        end
    end
`else
`endif

endmodule
